// File: rtl/global_signals_if.sv
// Chip-wide clock, reset and control strobes shared by the fetch-side blocks.
interface global_signals_if;
    logic clk;
    logic reset;
    logic delete_tagged;

    modport master (output clk, output reset, output delete_tagged);
    modport slave  (input clk, input reset, input delete_tagged);
endinterface

// File: rtl/instr_cache_if.sv
// Dual fetch-port lookup and single line-fill memory channel of the instruction cache.
interface instr_cache_if #(
    parameter int unsigned XLEN = 32
);
    logic [1:0][XLEN-1:0] address_in;
    logic [1:0][31:0]     instr_out;
    logic [1:0]           hit;
    logic                 mem_read;
    logic [XLEN-1:0]      mem_address;
    logic [31:0]          mem_data;
    logic                 mem_ready;

    modport master (
        output address_in, output mem_data, output mem_ready,
        input  instr_out, input hit, input mem_read, input mem_address
    );
    modport slave (
        input  address_in, input mem_data, input mem_ready,
        output instr_out, output hit, output mem_read, output mem_address
    );
endinterface

// File: rtl/instr_cache.sv
// Direct-mapped, two-port lookup instruction cache with 4-word lines filled one beat at a time.
module instr_cache #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned SETS = 16
) (
    global_signals_if.slave gsi,
    instr_cache_if.slave    bus
);
    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = XLEN - 4 - IDX_W;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [3:0][31:0] data_q [SETS];

    logic [0:0]      state_q;
    logic [1:0]      beat_q;
    logic [XLEN-1:0] base_q;
    logic [IDX_W-1:0] idx_q;

    logic [1:0][IDX_W-1:0] idx;
    logic [1:0][TAG_W-1:0] tag;
    logic [1:0][1:0]       off;
    logic [1:0]            port_hit;
    logic [XLEN-5:0]       fill_line;
    logic                  start_fill;
    logic                  last_beat;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            idx[i]           = bus.address_in[i][4+IDX_W-1:4];
            tag[i]           = bus.address_in[i][XLEN-1:4+IDX_W];
            off[i]           = bus.address_in[i][3:2];
            port_hit[i]      = valid_q[idx[i]] && (tag_q[idx[i]] == tag[i]);
            bus.instr_out[i] = port_hit[i] ? data_q[idx[i]][off[i]] : 32'h0;
        end
    end

    assign bus.hit = port_hit;

    // Port 0 has priority; when both miss on one line a single fill covers both.
    assign fill_line  = !port_hit[0] ? bus.address_in[0][XLEN-1:4] : bus.address_in[1][XLEN-1:4];
    assign start_fill = (state_q == IDLE) && (port_hit != 2'b11);
    assign last_beat  = (state_q == FILL) && bus.mem_ready && (beat_q == 2'd3);

    assign bus.mem_read    = (state_q == FILL);
    assign bus.mem_address = base_q + XLEN'({beat_q, 2'b00});

    always_ff @(posedge gsi.clk) begin
        if (gsi.reset) begin
            valid_q <= '0;
            state_q <= IDLE;
            beat_q  <= 2'd0;
            base_q  <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_fill) begin
                        base_q                          <= {fill_line, 4'h0};
                        idx_q                           <= fill_line[IDX_W-1:0];
                        valid_q[fill_line[IDX_W-1:0]] <= 1'b0;
                        beat_q                          <= 2'd0;
                        state_q                         <= FILL;
                    end
                end
                FILL: begin
                    if (bus.mem_ready) begin
                        beat_q <= beat_q + 2'd1;
                    end
                    if (last_beat) begin
                        valid_q[idx_q] <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Arrays carry no reset; the valid bits alone guard their contents.
    always_ff @(posedge gsi.clk) begin
        if (!gsi.reset && (state_q == FILL) && bus.mem_ready) begin
            data_q[idx_q][beat_q] <= bus.mem_data;
            if (beat_q == 2'd3) begin
                tag_q[idx_q] <= base_q[XLEN-1:4+IDX_W];
            end
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{bus.address_in[0][1:0], bus.address_in[1][1:0], gsi.delete_tagged};

endmodule

// File: tb/tb_instr_cache.sv
// Directed bench for instr_cache: cold/split miss, stall, eviction, reset mid-fill.
module tb_instr_cache;
    global_signals_if gsi ();
    instr_cache_if #(.XLEN(32)) bus ();

    instr_cache #(
        .XLEN(32),
        .SETS(16)
    ) dut (
        .gsi(gsi),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    initial gsi.clk = 1'b0;
    always #5 gsi.clk = ~gsi.clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tg, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tg, obs, exp);
    endtask

    task automatic tick();
        @(posedge gsi.clk);
        #1;
    endtask

    // Called in the first FILL cycle; leaves the bench in the cycle after the last beat.
    task automatic do_fill(input string tg, input logic [31:0] base, input logic [31:0] d0,
                           input int stall_beat, input int stall_len);
        for (int b = 0; b < 4; b++) begin
            if (b == stall_beat) begin
                for (int s = 0; s < stall_len; s++) begin
                    bus.mem_ready = 1'b0;
                    bus.mem_data  = 32'hDEAD_BEEF;
                    #1;
                    check({tg, " stall rd"}, {31'd0, bus.mem_read}, 32'd1);
                    check({tg, " stall addr"}, bus.mem_address, base + 32'(4 * b));
                    tick();
                end
            end
            bus.mem_ready = 1'b1;
            bus.mem_data  = d0 + 32'(b);
            #1;
            check({tg, " rd"}, {31'd0, bus.mem_read}, 32'd1);
            check({tg, " addr"}, bus.mem_address, base + 32'(4 * b));
            tick();
        end
        bus.mem_ready = 1'b0;
        bus.mem_data  = 32'h0;
    endtask

    task automatic do_reset();
        gsi.reset = 1'b1;
        tick();
        tick();
        gsi.reset = 1'b0;
    endtask

    initial begin
        gsi.reset         = 1'b1;
        gsi.delete_tagged = 1'b0;
        bus.address_in[0] = 32'h100;
        bus.address_in[1] = 32'h104;
        bus.mem_data      = 32'h0;
        bus.mem_ready     = 1'b0;

        // Reset state and cold miss
        tick();
        tick();
        check("rst hit", {30'd0, bus.hit}, 32'd0);
        check("rst out0", bus.instr_out[0], 32'h0);
        check("rst out1", bus.instr_out[1], 32'h0);
        check("rst rd", {31'd0, bus.mem_read}, 32'd0);
        check("rst addr", bus.mem_address, 32'h0);
        gsi.reset = 1'b0;
        #1;
        check("cold miss rd", {31'd0, bus.mem_read}, 32'd0);
        tick();
        do_fill("cold", 32'h100, 32'hA0, 9, 0);
        #1;
        check("cold hit", {30'd0, bus.hit}, 32'd3);
        check("cold out0", bus.instr_out[0], 32'hA0);
        check("cold out1", bus.instr_out[1], 32'hA1);
        check("cold rd done", {31'd0, bus.mem_read}, 32'd0);

        // Split miss: two lines, one IDLE cycle between fills
        bus.address_in[0] = 32'h10C;
        bus.address_in[1] = 32'h110;
        do_reset();
        #1;
        check("split miss hit", {30'd0, bus.hit}, 32'd0);
        tick();
        do_fill("split1", 32'h100, 32'hB0, 9, 0);
        #1;
        check("split gap rd", {31'd0, bus.mem_read}, 32'd0);
        check("split gap hit", {30'd0, bus.hit}, 32'd1);
        check("split gap out0", bus.instr_out[0], 32'hB3);
        check("split gap out1", bus.instr_out[1], 32'h0);
        tick();
        do_fill("split2", 32'h110, 32'hC0, 9, 0);
        #1;
        check("split hit", {30'd0, bus.hit}, 32'd3);
        check("split out1", bus.instr_out[1], 32'hC0);

        // Stall at beat 2, with delete_tagged asserted to show it is ignored
        gsi.delete_tagged = 1'b1;
        bus.address_in[0] = 32'h300;
        bus.address_in[1] = 32'h304;
        #1;
        check("stall miss hit", {30'd0, bus.hit}, 32'd0);
        tick();
        do_fill("stall", 32'h300, 32'hD0, 2, 5);
        gsi.delete_tagged = 1'b0;
        #1;
        check("stall hit", {30'd0, bus.hit}, 32'd3);
        check("stall out0", bus.instr_out[0], 32'hD0);
        check("stall out1", bus.instr_out[1], 32'hD1);

        // mem_ready in IDLE must not disturb anything
        bus.mem_ready = 1'b1;
        bus.mem_data  = 32'h1234_5678;
        tick();
        tick();
        bus.mem_ready = 1'b0;
        #1;
        check("idle rdy rd", {31'd0, bus.mem_read}, 32'd0);
        check("idle rdy hit", {30'd0, bus.hit}, 32'd3);
        check("idle rdy out0", bus.instr_out[0], 32'hD0);
        check("idle rdy out1", bus.instr_out[1], 32'hD1);

        // Conflict eviction: 0x000 and 0x100 share index 0
        bus.address_in[0] = 32'h000;
        bus.address_in[1] = 32'h000;
        tick();
        do_fill("evict1", 32'h000, 32'hE0, 9, 0);
        #1;
        check("evict1 hit", {30'd0, bus.hit}, 32'd3);
        check("evict1 out0", bus.instr_out[0], 32'hE0);
        bus.address_in[0] = 32'h100;
        #1;
        check("evict pre hit", {30'd0, bus.hit}, 32'd2);
        tick();
        check("evict clr hit", {30'd0, bus.hit}, 32'd0);
        do_fill("evict2", 32'h100, 32'hF0, 9, 0);
        #1;
        check("evict2 hit", {30'd0, bus.hit}, 32'd1);
        check("evict2 out0", bus.instr_out[0], 32'hF0);
        check("evict2 out1", bus.instr_out[1], 32'h0);

        // Reset mid-fill of 0x200 after beat 1
        bus.address_in[0] = 32'h200;
        bus.address_in[1] = 32'h200;
        tick();
        for (int b = 0; b < 2; b++) begin
            bus.mem_ready = 1'b1;
            bus.mem_data  = 32'h40 + 32'(b);
            tick();
        end
        gsi.reset = 1'b1;
        tick();
        gsi.reset     = 1'b0;
        bus.mem_ready = 1'b0;
        #1;
        check("midrst rd", {31'd0, bus.mem_read}, 32'd0);
        check("midrst addr", bus.mem_address, 32'h0);
        check("midrst hit", {30'd0, bus.hit}, 32'd0);
        tick();
        do_fill("refill", 32'h200, 32'h50, 9, 0);
        #1;
        check("refill hit", {30'd0, bus.hit}, 32'd3);
        check("refill out0", bus.instr_out[0], 32'h50);
        check("refill rd", {31'd0, bus.mem_read}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 Parameter: XLEN, 32, address width.
REQ-002 Parameter: SETS, 16, number of direct-mapped lines; power of two, at least 2.
REQ-003 Ports, clock and reset first:
- gsi.clk  input  1  clock, via global_signals_if gsi.
- gsi.reset  input  1  reset.
- address_in[2]  input  XLEN  fetch addresses per port; bits [1:0] ignored.
- instr_out[2]  output  32  instruction word per port.
- hit  output  2  hit[i] set when instr_out[i] is valid for address_in[i].
- mem_read  output  1  memory read request, held for a whole line fill.
- mem_address  output  XLEN  word address of the current fill beat.
- mem_data  input  32  returned word.
- mem_ready  input  1  mem_data valid this cycle; beat accepted.
REQ-004 One clock, gsi.clk; reset gsi.reset is synchronous and active-high.

Function
REQ-005 Geometry: line = 4 words (16 bytes); offset = addr[3:2]; index = addr[4+log2(SETS)-1:4]; tag = remaining upper bits.
REQ-006 Storage per line: valid bit, tag, 4 data words; all registered.
REQ-007 Lookup is combinational from stored state.
- hit[i] = valid[index_i] AND tag[index_i] == tag_i.
- instr_out[i] = data[index_i][offset_i] when hit[i] is set; otherwise 32'h0.
REQ-008 Both ports are looked up independently every cycle, including during a fill.
REQ-009 The FSM has two states, IDLE and FILL.
REQ-010 Transitions out of IDLE:
- Port 0 miss -> FILL on the line of address_in[0].
- Else port 1 miss -> FILL on the line of address_in[1].
- Else stay in IDLE.
REQ-011 On entering FILL:
- Latch the line base address (addr with [3:0] = 0) and the target index.
- Clear valid[index].
- Set beat counter to 0.
REQ-012 In FILL:
- mem_read = 1.
- mem_address = line_base + 4*beat.
- Each cycle with mem_ready = 1: write mem_data into data[index][beat] and increment beat.
REQ-013 Fill completion, in the cycle beat 3 is accepted:
- Write the tag.
- Set valid[index].
- Next state IDLE.
- mem_read is 0 from the next cycle.
REQ-014 Latency:
- Miss seen in IDLE in cycle N -> mem_read = 1 in cycle N+1.
- Last mem_ready in cycle M -> hit asserted for that line in cycle M+1.
REQ-015 A new fill is never started in the cycle the last beat is accepted. IDLE re-evaluates misses one cycle later, so back-to-back fills have one IDLE cycle between them.
REQ-016 Both ports missing on the same line -> one fill serves both.
REQ-017 Both ports missing on different lines -> port 0's line is filled first, then port 1's.
REQ-018 mem_ready while in IDLE is ignored.
REQ-019 In FILL, mem_address and mem_read remain stable while mem_ready = 0; there is no timeout.
REQ-020 A fill aborted by reset leaves its line invalid.
REQ-021 gsi.delete_tagged has no effect on this block; an in-flight fill completes.

Reset
REQ-022 When gsi.reset = 1 at a clock edge:
- All valid bits cleared.
- FSM -> IDLE; beat counter -> 0.
- mem_read -> 0; mem_address -> 0.
REQ-023 Tag and data arrays need not be reset.
REQ-024 Outputs right after reset: hit = 2'b00; instr_out[0] and instr_out[1] = 32'h0.
REQ-025 Reset has priority over every other event in the same cycle.

Verification
REQ-026 Cold miss:
- Stimulus: after reset, address_in[0] = 0x100, address_in[1] = 0x104; memory returns 0xA0..0xA3 with mem_ready every cycle.
- Required: mem_read = 1 and mem_address = 0x100, 0x104, 0x108, 0x10C.
- Required: next cycle hit = 2'b11, instr_out = {0xA0, 0xA1}.
REQ-027 Split miss:
- Stimulus: address_in[0] = 0x10C, address_in[1] = 0x110, both cold.
- Required: line 0x100 is filled, then one IDLE cycle, then line 0x110 is filled.
- Required: hit = 2'b01 between the two fills, 2'b11 after the second.
REQ-028 Stall:
- Stimulus: mem_ready held 0 for 5 cycles mid-fill, at beat 2.
- Required: mem_address holds at base+8 and mem_read stays 1 throughout.
- Required: fill completes normally once mem_ready returns.
REQ-029 Conflict eviction (SETS = 16):
- Stimulus: fill 0x000, then access 0x100 (same index, different tag).
- Required: hit[0] = 0 from the cycle valid is cleared; after the refill, 0x100 hits and 0x000 misses.
REQ-030 Reset mid-fill:
- Stimulus: assert reset after beat 1 of the fill of 0x200.
- Required: next cycle mem_read = 0 and FSM in IDLE.
- Required: 0x200 misses and triggers a fresh fill starting from beat 0.
